// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and sizing helpers for the pipelined prefix adder.
package adder_pkg;

   typedef enum logic {ADD, SUB} op_t;

   // Number of Kogge-Stone levels needed to span an operand of the given width.
   function automatic int LEVELS(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/pipelined_prefix_adder_level.sv
// One Kogge-Stone prefix level combining each (G,P) pair with the pair DIST bits below,
// optionally registered together with its valid bit and the pass-through sum bits.
module prefix_level #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1,
   parameter int REG   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             valid_prev,
   input  logic [WIDTH-1:0] g_prev,
   input  logic [WIDTH-1:0] p_prev,
   input  logic [WIDTH:0]   x_prev,
   output logic             valid_next,
   output logic [WIDTH-1:0] g_next,
   output logic [WIDTH-1:0] p_next,
   output logic [WIDTH:0]   x_next
);

   logic [WIDTH-1:0] g_comb;
   logic [WIDTH-1:0] p_comb;

   // Positions below DIST already hold complete groups and pass through untouched.
   always_comb begin
      g_comb = g_prev;
      p_comb = p_prev;
      for (int i = DIST; i < WIDTH; i++) begin
         g_comb[i] = g_prev[i] | (p_prev[i] & g_prev[i-DIST]);
         p_comb[i] = p_prev[i] & p_prev[i-DIST];
      end
   end

   generate
      if (REG != 0) begin : g_reg
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_next <= 1'b0;
               g_next     <= '0;
               p_next     <= '0;
               x_next     <= '0;
            end else if (en) begin
               valid_next <= valid_prev;
               g_next     <= g_comb;
               p_next     <= p_comb;
               x_next     <= x_prev;
            end
         end
      end else begin : g_comb_only
         logic unused_ctl;
         assign unused_ctl = clk ^ rst_n ^ en;
         assign valid_next = valid_prev;
         assign g_next     = g_comb;
         assign p_next     = p_comb;
         assign x_next     = x_prev;
      end
   endgenerate

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface and
// carry, signed-overflow and zero flags; a single stall signal freezes the whole pipe.
module pipelined_prefix_adder
   import adder_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int PIPELINED = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  op_t              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int LV = LEVELS(WIDTH);

   logic             stall;
   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] g0;
   logic [WIDTH-1:0] p0;
   logic [WIDTH-1:0] pbit;

   logic             s0_valid;
   logic [WIDTH-1:0] s0_g;
   logic [WIDTH-1:0] s0_p;
   logic [WIDTH:0]   s0_x;

   assign stall    = out_valid && !out_ready;
   assign en       = !stall;
   assign in_ready = en;

   // Carry-in is absorbed into bit 0, so that position's group already reaches down
   // to the carry-in and its group propagate is forced low.
   always_comb begin
      b_eff = (op == SUB) ? ~b : b;
      c0    = (op == SUB) ? 1'b1 : cin;
      pbit  = a ^ b_eff;
      g0    = a & b_eff;
      p0    = pbit;
      g0[0] = (a[0] & b_eff[0]) | (pbit[0] & c0);
      p0[0] = 1'b0;
   end

   // Stage 0 register; x carries the bitwise propagate and carry-in to the final XOR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_g     <= '0;
         s0_p     <= '0;
         s0_x     <= '0;
      end else if (en) begin
         s0_valid <= in_valid;
         s0_g     <= g0;
         s0_p     <= p0;
         s0_x     <= {pbit, c0};
      end
   end

   genvar k;
   generate
      for (k = 0; k < LV; k++) begin : lvl
         logic             vi;
         logic [WIDTH-1:0] gi;
         logic [WIDTH-1:0] pi;
         logic [WIDTH:0]   xi;
         logic             v;
         logic [WIDTH-1:0] g;
         logic [WIDTH-1:0] p;
         logic [WIDTH:0]   x;

         if (k == 0) begin : g_first
            assign vi = s0_valid;
            assign gi = s0_g;
            assign pi = s0_p;
            assign xi = s0_x;
         end else begin : g_chain
            assign vi = lvl[k-1].v;
            assign gi = lvl[k-1].g;
            assign pi = lvl[k-1].p;
            assign xi = lvl[k-1].x;
         end

         prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .REG   ((PIPELINED != 0) ? 1 : 0)
         ) u_level (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .valid_prev (vi),
            .g_prev     (gi),
            .p_prev     (pi),
            .x_prev     (xi),
            .valid_next (v),
            .g_next     (g),
            .p_next     (p),
            .x_next     (x)
         );
      end
   endgenerate

   logic [WIDTH-1:0] gf;
   logic [WIDTH:0]   xf;
   logic             unused_p;

   assign gf        = lvl[LV-1].g;
   assign xf        = lvl[LV-1].x;
   assign unused_p  = ^lvl[LV-1].p;
   assign out_valid = lvl[LV-1].v;

   // Overflow is the carry into the MSB differing from the carry out of it.
   assign y    = xf[WIDTH:1] ^ {gf[WIDTH-2:0], xf[0]};
   assign cout = gf[WIDTH-1];
   assign ovf  = gf[WIDTH-1] ^ gf[WIDTH-2];
   assign zero = out_valid & ~|y;

endmodule
